alu_issue: RTL and testbench
============================

// Module: alu_issue
// PURPOSE
//  Issue/decode stage driving the execute-stage ALU: accepts a fetched RV32 instruction, reads rs1/rs2,
//  forwards writeback data, builds op1/op2/opcode/funct3/funct7 and holds them in a registered
//  valid/ready slot until execute accepts. Sits between fetch and the ALU in each core.
// PARAMETERS
//  WIDTH  32  datapath width; shift amounts use $clog2(WIDTH) bits
//  NREGS  32  architectural registers; index width $clog2(NREGS)
// PORTS
//  clk        in   1      core clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      fetch offers instr
//  in_ready   out  1      stage can accept this cycle
//  instr      in   32     instruction word
//  rs1_addr   out  5      regfile read port A, = instr[19:15], combinational
//  rs2_addr   out  5      regfile read port B, = instr[24:20], combinational
//  rs1_data   in   WIDTH  regfile read data A, same cycle
//  rs2_data   in   WIDTH  regfile read data B, same cycle
//  wb_en      in   1      writeback valid
//  wb_rd      in   5      writeback destination
//  wb_data    in   WIDTH  writeback value
//  flush      in   1      discard held and incoming instruction
//  out_valid  out  1      issue slot full
//  out_ready  in   1      ALU/execute accepts
//  op1,op2    out  WIDTH  ALU operands
//  opcode     out  7      instr[6:0]
//  funct3     out  3      instr[14:12]
//  funct7     out  7      instr[31:25]
//  rd         out  5      instr[11:7]
//  illegal    out  1      held instruction not an ALU op
//  issue_count out 32     instructions handed to execute
// BEHAVIOUR
//  - Reset: out_valid=0, op1/op2/opcode/funct3/funct7/rd=0, illegal=0, issue_count=0.
//  - in_ready = !out_valid || out_ready (combinational). Load when in_valid && in_ready && !flush;
//    1-cycle latency; outputs stable while out_valid && !out_ready.
//  - Operand read: x0 reads 0. Else if wb_en && wb_rd==rsN use wb_data, else rsN_data.
//  - OP (0110011): op1=rs1, op2=rs2. Legal funct7: 0000000 any funct3; 0100000 with funct3 000/101;
//    0000001 per M_EXT_EN.
//  - OPIMM (0010011): op1=rs1. funct3 001/101: op2=zero-extended instr[24:20]; funct7 must be 0000000,
//    or 0100000 only with funct3 101. Otherwise op2=sign-extended instr[31:20]; funct7 driven 0000000.
//  - Other opcodes: illegal=1, op1=op2=0. Illegal instructions still issue (out_valid=1).
//  - Hold-forward: while held, wb_en with wb_rd!=0 matching stored rs1 updates op1; matching rs2 updates
//    op2 only when opcode==OP. Both matching updates both.
//  - flush: next cycle out_valid=0; same-cycle in_valid dropped; issue_count unchanged. flush wins over
//    out_ready and load.
//  - Output handshake and refill same cycle: slot reloads without a bubble.
//  - issue_count += 1 on out_valid && out_ready && !flush; wraps 0xFFFFFFFF->0.
// CONFIGURATION
//  ALU_ISSUE_M_EXT_EN defined: OP funct7 0000001 legal for funct3 000 (MUL), 100 (DIV), 110 (REM);
//  other funct3 illegal. Undefined: every funct7 0000001 is illegal.
// STRUCTURE
//  riscv_pkg: OP/OPIMM opcodes, funct3/funct7 constants, issue_slot_t struct
//  (op1, op2, opcode, funct3, funct7, rd, rs1, rs2, illegal).
//  Sub-module alu_issue_decode: combinational legality check, imm/shamt generation, op2 select.
// TESTING
//  1 addi x5,x1,-1 (0xFFF08293), x1=7, out_ready=1 -> next cycle op1=7, op2=0xFFFFFFFF, funct3=000, illegal=0
//  2 sub x3,x1,x2, wb_en same cycle wb_rd=2 wb_data=9, rs2_data=4 -> op2=9, funct7=0100000
//  3 out_ready=0 holding add x3,x1,x2; wb x1=0x55 -> op1=0x55 next cycle; in_ready=0; outputs else unchanged
//  4 mul x3,x1,x2 (0x022081B3): M_EXT_EN defined -> illegal=0; undefined -> illegal=1; lui 0x000012B7 -> illegal=1, op1=op2=0
//  5 flush with out_valid=1, in_valid=1, out_ready=1 -> out_valid=0 next cycle, issue_count unchanged
//  6 back-to-back 3 instrs, out_ready=1 -> out_valid high 3 cycles, no bubble, issue_count=3; rst mid-stream -> all 0

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the issue-slot bundle for the ALU issue stage.
// Optional ALU_ISSUE_M_EXT_EN admits MUL/DIV/REM encodings at decode.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_MUL = 3'b000;
    localparam logic [2:0] F3_DIV = 3'b100;
    localparam logic [2:0] F3_REM = 3'b110;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            illegal;
    } issue_slot_t;

endpackage

// File: rtl/alu_issue_if.sv
// Fetch-in / execute-out handshake bundle of the ALU issue stage.
// slave is the issue stage, master is the surrounding pipeline.
interface alu_issue_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rd;
    logic             illegal;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, op1, op2,
        output opcode, funct3, funct7, rd, illegal
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, op1, op2,
        input  opcode, funct3, funct7, rd, illegal
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational legality check, immediate/shamt build and op2 select.
// ALU_ISSUE_M_EXT_EN makes MUL/DIV/REM (funct7 0000001) legal.
module alu_issue_decode
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [11:0]      i_imm12,
    input  logic [WIDTH-1:0] i_rs1_val,
    input  logic [WIDTH-1:0] i_rs2_val,
    output logic [WIDTH-1:0] o_op1,
    output logic [WIDTH-1:0] o_op2,
    output logic [6:0]       o_funct7,
    output logic             o_illegal
);
    localparam int SHW = $clog2(WIDTH);

    logic [6:0]       w_f7;
    logic [WIDTH-1:0] w_shamt;
    logic [WIDTH-1:0] w_imm;
    logic             w_is_op;
    logic             w_is_opimm;
    logic             w_is_shift;
    logic             w_alt_ok;
    logic             w_mext_ok;

    assign w_f7       = i_imm12[11:5];
    assign w_shamt    = {{(WIDTH-SHW){1'b0}}, i_imm12[SHW-1:0]};
    assign w_imm      = {{(WIDTH-12){i_imm12[11]}}, i_imm12};
    assign w_is_op    = (i_opcode == OPC_OP);
    assign w_is_opimm = (i_opcode == OPC_OPIMM);
    assign w_is_shift = (i_funct3 == F3_SLL) || (i_funct3 == F3_SR);
    assign w_alt_ok   = (i_funct3 == F3_ADD) || (i_funct3 == F3_SR);

`ifdef ALU_ISSUE_M_EXT_EN
    assign w_mext_ok = (w_f7 == F7_MULDIV) &&
                       ((i_funct3 == F3_MUL) ||
                        (i_funct3 == F3_DIV) ||
                        (i_funct3 == F3_REM));
`else
    assign w_mext_ok = 1'b0;
`endif

    always_comb begin
        o_op1     = '0;
        o_op2     = '0;
        o_funct7  = w_f7;
        o_illegal = 1'b1;
        unique case (1'b1)
            w_is_op: begin
                o_op1     = i_rs1_val;
                o_op2     = i_rs2_val;
                o_illegal = !((w_f7 == F7_BASE) ||
                              ((w_f7 == F7_ALT) && w_alt_ok) ||
                              w_mext_ok);
            end
            w_is_opimm: begin
                o_op1 = i_rs1_val;
                if (w_is_shift) begin
                    o_op2     = w_shamt;
                    o_illegal = !((w_f7 == F7_BASE) ||
                                  ((w_f7 == F7_ALT) &&
                                   (i_funct3 == F3_SR)));
                end else begin
                    // upper imm bits are not a funct7 here
                    o_op2     = w_imm;
                    o_funct7  = F7_BASE;
                    o_illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_issue.sv
// Issue stage: reads/forwards operands and holds one decoded ALU op
// in a valid/ready slot. ALU_ISSUE_M_EXT_EN enables M-extension ops.
module alu_issue
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_issue_if.slave               bus,
    output logic [$clog2(NREGS)-1:0] rs1_addr,
    output logic [$clog2(NREGS)-1:0] rs2_addr,
    input  logic [WIDTH-1:0]         rs1_data,
    input  logic [WIDTH-1:0]         rs2_data,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic [WIDTH-1:0]         wb_data,
    input  logic                     flush,
    output logic [31:0]              issue_count
);
    localparam int AW = $clog2(NREGS);

    issue_slot_t      r_slot;
    logic             r_valid;
    logic [31:0]      r_count;

    logic [WIDTH-1:0] w_rs1_val;
    logic [WIDTH-1:0] w_rs2_val;
    logic [WIDTH-1:0] w_dec_op1;
    logic [WIDTH-1:0] w_dec_op2;
    logic [6:0]       w_dec_f7;
    logic             w_dec_ill;
    logic             w_in_ready;
    logic             w_load;
    logic             w_fire;
    logic             w_wb_any;
    logic             w_hit1;
    logic             w_hit2;
    logic             w_has_rs1;
    logic             w_has_rs2;
    issue_slot_t      w_next;

    assign rs1_addr = bus.instr[15 +: AW];
    assign rs2_addr = bus.instr[20 +: AW];

    // x0 always reads zero, even against a same-cycle writeback
    assign w_rs1_val = (rs1_addr == '0) ? '0 :
                       (wb_en && wb_rd == rs1_addr) ? wb_data : rs1_data;
    assign w_rs2_val = (rs2_addr == '0) ? '0 :
                       (wb_en && wb_rd == rs2_addr) ? wb_data : rs2_data;

    alu_issue_decode #(
        .WIDTH(WIDTH)
    ) u_decode (
        .i_opcode (bus.instr[6:0]),
        .i_funct3 (bus.instr[14:12]),
        .i_imm12  (bus.instr[31:20]),
        .i_rs1_val(w_rs1_val),
        .i_rs2_val(w_rs2_val),
        .o_op1    (w_dec_op1),
        .o_op2    (w_dec_op2),
        .o_funct7 (w_dec_f7),
        .o_illegal(w_dec_ill)
    );

    always_comb begin
        w_next         = '0;
        w_next.op1     = XLEN'(w_dec_op1);
        w_next.op2     = XLEN'(w_dec_op2);
        w_next.opcode  = bus.instr[6:0];
        w_next.funct3  = bus.instr[14:12];
        w_next.funct7  = w_dec_f7;
        w_next.rd      = bus.instr[11:7];
        w_next.rs1     = bus.instr[19:15];
        w_next.rs2     = bus.instr[24:20];
        w_next.illegal = w_dec_ill;
    end

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_load     = bus.in_valid && w_in_ready && !flush;
    assign w_fire     = r_valid && bus.out_ready && !flush;

    // operands of a held op track later writebacks to its sources
    assign w_wb_any  = wb_en && (wb_rd != '0);
    assign w_has_rs2 = (r_slot.opcode == OPC_OP);
    assign w_has_rs1 = w_has_rs2 || (r_slot.opcode == OPC_OPIMM);
    assign w_hit1    = w_wb_any && w_has_rs1 &&
                       (5'(wb_rd) == r_slot.rs1);
    assign w_hit2    = w_wb_any && w_has_rs2 &&
                       (5'(wb_rd) == r_slot.rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot  <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            if (w_fire) begin
                r_count <= r_count + 32'd1;
            end
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
                r_slot  <= w_next;
            end else if (bus.out_ready) begin
                r_valid <= 1'b0;
            end else if (r_valid) begin
                if (w_hit1) r_slot.op1 <= XLEN'(wb_data);
                if (w_hit2) r_slot.op2 <= XLEN'(wb_data);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.op1       = WIDTH'(r_slot.op1);
    assign bus.op2       = WIDTH'(r_slot.op2);
    assign bus.opcode    = r_slot.opcode;
    assign bus.funct3    = r_slot.funct3;
    assign bus.funct7    = r_slot.funct7;
    assign bus.rd        = r_slot.rd;
    assign bus.illegal   = r_slot.illegal;
    assign issue_count   = r_count;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: vector table plus scoreboard, and hand sequences
// for hold-forward, refill, flush, back-to-back issue and mid-stream reset.
module tb_alu_issue;

`ifdef ALU_ISSUE_M_EXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        wen;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [6:0]  ef7;
        logic        eill;
    } vec_t;

    localparam int NV = 16;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [31:0] issue_count;

    int   n_cmp;
    int   n_fail;
    int   exp_count;
    exp_t sb[$];
    vec_t vec[NV];

    alu_issue_if #(.WIDTH(32)) ifc ();

    alu_issue #(.WIDTH(32), .NREGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (ifc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flush      (flush),
        .issue_count(issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(logic [6:0] f7, logic [4:0] s2,
                                          logic [4:0] s1, logic [2:0] f3,
                                          logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(logic [11:0] imm, logic [4:0] s1,
                                          logic [2:0] f3, logic [4:0] d);
        return {imm, s1, f3, d, 7'b0010011};
    endfunction

    function automatic exp_t mk_exp(logic [31:0] ins, logic [31:0] a,
                                    logic [31:0] b, logic [6:0] f7,
                                    logic ill);
        exp_t e;
        e.op1 = a;
        e.op2 = b;
        e.opc = ins[6:0];
        e.f3  = ins[14:12];
        e.f7  = f7;
        e.rd  = ins[11:7];
        e.ill = ill;
        return e;
    endfunction

    function automatic vec_t mkv(logic [31:0] ins, logic [31:0] r1,
                                 logic [31:0] r2, logic wen,
                                 logic [4:0] wrd, logic [31:0] wdat,
                                 logic [31:0] e1, logic [31:0] e2,
                                 logic [6:0] ef7, logic eill);
        vec_t v;
        v.instr = ins;
        v.r1    = r1;
        v.r2    = r2;
        v.wen   = wen;
        v.wrd   = wrd;
        v.wdat  = wdat;
        v.e1    = e1;
        v.e2    = e2;
        v.ef7   = ef7;
        v.eill  = eill;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (!rst && ifc.out_valid === 1'b1 && ifc.out_ready && !flush) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_issue: op1=%h", ifc.op1);
            end else begin
                e = sb.pop_front();
                g = {ifc.op1, ifc.op2, ifc.opcode, ifc.funct3,
                     ifc.funct7, ifc.rd, ifc.illegal};
                exp_count++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL issue#%0d: got op1=%h op2=%h opc=%h f3=%h f7=%h rd=%0d ill=%b expected op1=%h op2=%h opc=%h f3=%h f7=%h rd=%0d ill=%b",
                             exp_count, g.op1, g.op2, g.opc, g.f3, g.f7,
                             g.rd, g.ill, e.op1, e.op2, e.opc, e.f3, e.f7,
                             e.rd, e.ill);
                end
            end
        end
    end

    initial begin
        int c0;
        n_cmp     = 0;
        n_fail    = 0;
        exp_count = 0;

        vec[0]  = mkv(itype(12'hFFF, 1, 0, 5), 7, 0, 0, 0, 0,
                      32'd7, 32'hFFFF_FFFF, 7'h00, 0);
        vec[1]  = mkv(rtype(7'h20, 2, 1, 0, 3), 20, 4, 1, 2, 9,
                      32'd20, 32'd9, 7'h20, 0);
        vec[2]  = mkv(rtype(7'h00, 2, 0, 0, 3), 123, 5, 0, 0, 0,
                      32'd0, 32'd5, 7'h00, 0);
        vec[3]  = mkv(itype(12'h01F, 1, 1, 4), 32'hAAAA_0000, 0, 0, 0, 0,
                      32'hAAAA_0000, 32'd31, 7'h00, 0);
        vec[4]  = mkv(itype(12'h403, 1, 5, 4), 32'h8000_0000, 0, 0, 0, 0,
                      32'h8000_0000, 32'd3, 7'h20, 0);
        vec[5]  = mkv(itype(12'h403, 1, 1, 4), 1, 0, 0, 0, 0,
                      32'd1, 32'd3, 7'h20, 1);
        vec[6]  = mkv(itype(12'h7FF, 1, 4, 6), 32'h0F0F, 0, 0, 0, 0,
                      32'h0F0F, 32'h7FF, 7'h00, 0);
        vec[7]  = mkv(rtype(7'h20, 2, 1, 6, 3), 1, 2, 0, 0, 0,
                      32'd1, 32'd2, 7'h20, 1);
        vec[8]  = mkv(32'h0220_81B3, 6, 7, 0, 0, 0,
                      32'd6, 32'd7, 7'h01, !MEXT);
        vec[9]  = mkv(rtype(7'h01, 2, 1, 1, 3), 6, 7, 0, 0, 0,
                      32'd6, 32'd7, 7'h01, 1);
        vec[10] = mkv(rtype(7'h01, 2, 1, 4, 3), 6, 7, 0, 0, 0,
                      32'd6, 32'd7, 7'h01, !MEXT);
        vec[11] = mkv(32'h0000_12B7, 5, 5, 0, 0, 0,
                      32'd0, 32'd0, 7'h00, 1);
        vec[12] = mkv(rtype(7'h00, 2, 0, 0, 3), 11, 12, 1, 0, 32'h99,
                      32'd0, 32'd12, 7'h00, 0);
        vec[13] = mkv(rtype(7'h00, 1, 1, 7, 3), 1, 1, 1, 1, 32'hDEAD,
                      32'hDEAD, 32'hDEAD, 7'h00, 0);
        vec[14] = mkv(itype(12'h800, 1, 0, 2), 3, 0, 0, 0, 0,
                      32'd3, 32'hFFFF_F800, 7'h00, 0);
        vec[15] = mkv(rtype(7'h20, 2, 1, 5, 3), 8, 9, 0, 0, 0,
                      32'd8, 32'd9, 7'h20, 0);

        rst           = 1'b1;
        flush         = 1'b0;
        wb_en         = 1'b0;
        wb_rd         = '0;
        wb_data       = '0;
        rs1_data      = '0;
        rs2_data      = '0;
        ifc.in_valid  = 1'b0;
        ifc.instr     = '0;
        ifc.out_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_out_valid", 32'(ifc.out_valid), 0);
        chk("rst_ops", ifc.op1 | ifc.op2, 0);
        chk("rst_fields", {ifc.opcode, ifc.funct3, ifc.funct7, ifc.rd}, 0);
        chk("rst_illegal", 32'(ifc.illegal), 0);
        chk("rst_count", issue_count, 0);
        step();
        rst = 1'b0;

        ifc.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            step();
            ifc.in_valid = 1'b1;
            ifc.instr    = vec[i].instr;
            rs1_data     = vec[i].r1;
            rs2_data     = vec[i].r2;
            wb_en        = vec[i].wen;
            wb_rd        = vec[i].wrd;
            wb_data      = vec[i].wdat;
            sb.push_back(mk_exp(vec[i].instr, vec[i].e1, vec[i].e2,
                                vec[i].ef7, vec[i].eill));
            @(negedge clk);
            if (i == 0) chk("rs_addr", {27'd0, rs1_addr}, 1);
            else chk("nobubble", 32'(ifc.out_valid), 1);
        end
        step();
        ifc.in_valid = 1'b0;
        wb_en        = 1'b0;
        @(negedge clk);
        chk("tbl_last_valid", 32'(ifc.out_valid), 1);
        step();
        @(negedge clk);
        chk("tbl_count", issue_count, NV);
        chk("tbl_drained", 32'(ifc.out_valid), 0);

        step();
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.instr     = rtype(7'h00, 2, 1, 0, 3);
        rs1_data      = 1;
        rs2_data      = 2;
        @(negedge clk);
        chk("hold_in_ready_empty", 32'(ifc.in_ready), 1);
        step();
        ifc.in_valid = 1'b0;
        wb_en        = 1'b1;
        wb_rd        = 1;
        wb_data      = 32'h55;
        @(negedge clk);
        chk("hold_valid", 32'(ifc.out_valid), 1);
        chk("hold_op1_pre", ifc.op1, 1);
        chk("hold_in_ready", 32'(ifc.in_ready), 0);
        step();
        wb_rd   = 2;
        wb_data = 32'h66;
        @(negedge clk);
        chk("hold_fwd_op1", ifc.op1, 32'h55);
        chk("hold_op2_kept", ifc.op2, 2);
        step();
        wb_en = 1'b0;
        @(negedge clk);
        chk("hold_fwd_op2", ifc.op2, 32'h66);
        chk("hold_op1_kept", ifc.op1, 32'h55);
        chk("hold_rd", {27'd0, ifc.rd}, 3);
        step();
        sb.push_back(mk_exp(rtype(7'h00, 2, 1, 0, 3), 32'h55, 32'h66, 0, 0));
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.instr     = itype(12'd5, 2, 0, 7);
        rs1_data      = 10;
        rs2_data      = 0;
        @(negedge clk);
        chk("refill_in_ready", 32'(ifc.in_ready), 1);
        step();
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b0;
        wb_en         = 1'b1;
        wb_rd         = 5;
        wb_data       = 32'h77;
        @(negedge clk);
        chk("refill_valid", 32'(ifc.out_valid), 1);
        chk("refill_op1", ifc.op1, 10);
        step();
        wb_rd   = 2;
        wb_data = 32'h44;
        @(negedge clk);
        chk("opimm_no_rs2_fwd", ifc.op2, 5);
        step();
        wb_en = 1'b0;
        @(negedge clk);
        chk("opimm_rs1_fwd", ifc.op1, 32'h44);
        step();
        sb.push_back(mk_exp(itype(12'd5, 2, 0, 7), 32'h44, 32'd5, 0, 0));
        ifc.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("hold_drained", 32'(ifc.out_valid), 0);

        step();
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.instr     = rtype(7'h00, 2, 1, 0, 3);
        rs1_data      = 3;
        rs2_data      = 4;
        step();
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_valid", 32'(ifc.out_valid), 1);
        c0 = exp_count;
        step();
        flush         = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.instr     = itype(12'd1, 1, 0, 1);
        ifc.out_ready = 1'b1;
        step();
        flush        = 1'b0;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(ifc.out_valid), 0);
        chk("flush_count", issue_count, c0);

        c0 = exp_count;
        for (int i = 0; i < 3; i++) begin
            step();
            ifc.in_valid = 1'b1;
            ifc.instr    = itype(12'(i + 1), 1, 0, 5'(i + 1));
            rs1_data     = 32'(100 * i);
            sb.push_back(mk_exp(ifc.instr, 32'(100 * i), 32'(i + 1), 0, 0));
            @(negedge clk);
            if (i > 0) chk("b2b_valid", 32'(ifc.out_valid), 1);
        end
        step();
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid_last", 32'(ifc.out_valid), 1);
        step();
        @(negedge clk);
        chk("b2b_count", issue_count, 32'(c0 + 3));

        step();
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.instr     = rtype(7'h00, 2, 1, 0, 3);
        rs1_data      = 32'h1234;
        step();
        ifc.instr = itype(12'h123, 1, 0, 9);
        rst       = 1'b1;
        step();
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(ifc.out_valid), 0);
        chk("mid_rst_ops", ifc.op1 | ifc.op2, 0);
        chk("mid_rst_fields", {ifc.opcode, ifc.funct3, ifc.funct7,
                               ifc.rd, ifc.illegal}, 0);
        chk("mid_rst_count", issue_count, 0);

        step();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
